// File: rtl/pwu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pwu_req_arbiter
// Description : Shares one PWU translation port between NUM_REQ requesters.
//               It arbitrates VA requests round-robin with no added latency.
//               Because the PWU answers in issue order, a FIFO of requester
//               IDs (tags) sends each returned PA and fault to its issuer.
//               Optional feature macro: PWUARB_FAULT_CNT_EN adds saturating
//               per-requester fault counters on fault_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module pwu_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // requester VA side
    input  logic [NUM_REQ*32-1:0]       req_va_i,
    input  logic [NUM_REQ-1:0]          req_vld_i,
    output logic [NUM_REQ-1:0]          req_rdy_o,
    // requester response side
    output logic [27:0]                 rsp_pa_o,
    output logic                        rsp_fault_o,
    output logic [NUM_REQ-1:0]          rsp_vld_o,
    input  logic [NUM_REQ-1:0]          rsp_rdy_i,
    // PWU VA side
    output logic [31:0]                 pwu_va_o,
    output logic                        pwu_va_vld_o,
    input  logic                        pwu_va_rdy_i,
    // PWU PA side
    input  logic [27:0]                 pwu_pa_i,
    input  logic                        pwu_pa_vld_i,
    input  logic                        pwu_pa_fault_i,
    output logic                        pwu_pa_rdy_o,
    // status
    output logic [$clog2(MAX_OUTST):0]  outst_o,
    output logic                        err_o
`ifdef PWUARB_FAULT_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]       fault_cnt_o
`endif
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   fifo_q [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [31:0]       w_va [NUM_REQ];
    logic              w_grant_vld;
    logic [ID_W-1:0]   w_grant_id;
    logic [ID_W:0]     w_scan_idx;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_orphan;
    logic [ID_W-1:0]   w_head;

    // Split the flat VA bus into one word per requester.
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_va_unpack
            assign w_va[k] = req_va_i[32*k +: 32];
        end
    endgenerate

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (w_scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_scan_idx = w_scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_grant_vld && req_vld_i[w_scan_idx[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_scan_idx[ID_W-1:0];
            end
        end
    end

    // Fullness uses the registered count, so a pop cannot open a slot for an
    // issue in the same cycle.
    assign w_full   = (count_q == CNT_W'(MAX_OUTST));
    assign w_empty  = (count_q == '0);

    assign w_issue      = !rst_i && w_grant_vld && !w_full;
    assign w_push       = w_issue && pwu_va_rdy_i;
    assign pwu_va_vld_o = w_issue;
    assign pwu_va_o     = w_va[w_grant_id];

    // Only the granted requester sees the PWU ready.
    always_comb begin
        req_rdy_o = '0;
        if (w_issue) begin
            req_rdy_o[w_grant_id] = pwu_va_rdy_i;
        end
    end

    // Return path: the FIFO head names the owner of the next PWU response.
    assign w_head       = fifo_q[rd_ptr_q];
    assign w_pop        = !rst_i && pwu_pa_vld_i && !w_empty && rsp_rdy_i[w_head];
    assign w_orphan     = !rst_i && pwu_pa_vld_i && w_empty;
    assign pwu_pa_rdy_o = !rst_i && (w_empty || rsp_rdy_i[w_head]);
    assign rsp_pa_o     = pwu_pa_i;
    assign rsp_fault_o  = pwu_pa_fault_i;

    // Steer the response valid to the head owner only.
    always_comb begin
        rsp_vld_o = '0;
        if (!rst_i && pwu_pa_vld_i && !w_empty) begin
            rsp_vld_o[w_head] = 1'b1;
        end
    end

    // Next-state for pointers, occupancy and the sticky error.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_push) begin
            if (w_grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = w_grant_id + ID_W'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        err_d    = err_q | w_orphan;
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Tag storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= w_grant_id;
        end
    end

    assign outst_o = count_q;
    assign err_o   = err_q;

`ifdef PWUARB_FAULT_CNT_EN
    // Per-requester saturating count of faulted responses actually delivered.
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_fault_cnt
            logic [15:0] cnt_q;

            // Count a pop to requester k that carries a fault, stopping at max.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (w_pop && (w_head == ID_W'(k)) && pwu_pa_fault_i
                             && (cnt_q != 16'hFFFF)) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end

            assign fault_cnt_o[16*k +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwu_req_arbiter
// Description : Directed scoreboard bench for pwu_req_arbiter (NUM_REQ=4,
//               MAX_OUTST=8). The stimulus queues the expected VA issues and
//               PA deliveries. A negedge monitor pops each one and compares
//               it when a handshake happens.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwu_req_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_OUTST = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NUM_REQ*32-1:0] req_va_i;
    logic [NUM_REQ-1:0]    req_vld_i;
    logic [NUM_REQ-1:0]    req_rdy_o;
    logic [27:0]           rsp_pa_o;
    logic                  rsp_fault_o;
    logic [NUM_REQ-1:0]    rsp_vld_o;
    logic [NUM_REQ-1:0]    rsp_rdy_i;
    logic [31:0]           pwu_va_o;
    logic                  pwu_va_vld_o;
    logic                  pwu_va_rdy_i;
    logic [27:0]           pwu_pa_i;
    logic                  pwu_pa_vld_i;
    logic                  pwu_pa_fault_i;
    logic                  pwu_pa_rdy_o;
    logic [3:0]            outst_o;
    logic                  err_o;
`ifdef PWUARB_FAULT_CNT_EN
    logic [NUM_REQ*16-1:0] fault_cnt_o;
`endif

    pwu_req_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_va_i       (req_va_i),
        .req_vld_i      (req_vld_i),
        .req_rdy_o      (req_rdy_o),
        .rsp_pa_o       (rsp_pa_o),
        .rsp_fault_o    (rsp_fault_o),
        .rsp_vld_o      (rsp_vld_o),
        .rsp_rdy_i      (rsp_rdy_i),
        .pwu_va_o       (pwu_va_o),
        .pwu_va_vld_o   (pwu_va_vld_o),
        .pwu_va_rdy_i   (pwu_va_rdy_i),
        .pwu_pa_i       (pwu_pa_i),
        .pwu_pa_vld_i   (pwu_pa_vld_i),
        .pwu_pa_fault_i (pwu_pa_fault_i),
        .pwu_pa_rdy_o   (pwu_pa_rdy_o),
        .outst_o        (outst_o),
        .err_o          (err_o)
`ifdef PWUARB_FAULT_CNT_EN
        ,
        .fault_cnt_o    (fault_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] va;
    } issue_t;

    typedef struct {
        logic [1:0]  id;
        logic [27:0] pa;
        logic        fault;
    } rsp_t;

    issue_t      exp_issue [$];
    rsp_t        exp_rsp   [$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] va_tab [NUM_REQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_va(input int k, input logic [31:0] v);
        va_tab[k] = v;
        req_va_i[32*k +: 32] = v;
    endtask

    task automatic exp_iss(input int id);
        issue_t e;
        e.id = 2'(id);
        e.va = va_tab[id];
        exp_issue.push_back(e);
    endtask

    task automatic exp_ret(input int id, input logic [27:0] pa, input logic fault);
        rsp_t e;
        e.id    = 2'(id);
        e.pa    = pa;
        e.fault = fault;
        exp_rsp.push_back(e);
    endtask

    // Monitor: compare each observed handshake against the scoreboard head.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (pwu_va_vld_o && pwu_va_rdy_i) begin
                if (exp_issue.size() == 0) begin
                    chk("unexpected_issue", {28'd0, req_rdy_o}, 32'd0);
                end else begin
                    issue_t e;
                    e = exp_issue.pop_front();
                    chk("issue_grant", {28'd0, req_rdy_o}, {28'd0, 4'b0001 << e.id});
                    chk("issue_va", pwu_va_o, e.va);
                end
            end
            if ((rsp_vld_o & rsp_rdy_i) != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", {28'd0, rsp_vld_o}, 32'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_vld", {28'd0, rsp_vld_o}, {28'd0, 4'b0001 << r.id});
                    chk("rsp_pa", {4'd0, rsp_pa_o}, {4'd0, r.pa});
                    chk("rsp_fault", {31'd0, rsp_fault_o}, {31'd0, r.fault});
                end
            end
        end
    end

    initial begin
        int ids [5];
        int ids2 [8];
        ids  = '{0, 1, 2, 3, 0};
        ids2 = '{2, 3, 0, 1, 2, 3, 0, 1};

        rst_i          = 1'b1;
        req_va_i       = '0;
        req_vld_i      = 4'hF;
        rsp_rdy_i      = 4'hF;
        pwu_va_rdy_i   = 1'b1;
        pwu_pa_i       = '0;
        pwu_pa_vld_i   = 1'b0;
        pwu_pa_fault_i = 1'b0;
        set_va(0, 32'h1111_0000);
        set_va(1, 32'h2222_0004);
        set_va(2, 32'h3333_0008);
        set_va(3, 32'h4444_000C);

        // T1: reset with every requester valid
        repeat (2) begin
            step();
            chk("rst_req_rdy", {28'd0, req_rdy_o}, 32'd0);
            chk("rst_va_vld", {31'd0, pwu_va_vld_o}, 32'd0);
            chk("rst_rsp_vld", {28'd0, rsp_vld_o}, 32'd0);
            chk("rst_pa_rdy", {31'd0, pwu_pa_rdy_o}, 32'd0);
            chk("rst_outst", {28'd0, outst_o}, 32'd0);
            chk("rst_err", {31'd0, err_o}, 32'd0);
        end
        rst_i     = 1'b0;
        req_vld_i = 4'h0;
        step();

        // T2: round robin with all valid
        req_vld_i = 4'hF;
        foreach (ids[i]) exp_iss(ids[i]);
        repeat (5) step();
        req_vld_i = 4'h0;
        chk("t2_outst", {28'd0, outst_o}, 32'd5);
        pwu_pa_vld_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pwu_pa_i       = 28'h0100000 + 28'(i);
            pwu_pa_fault_i = (i == 2);
            exp_ret(ids[i], pwu_pa_i, pwu_pa_fault_i);
            step();
        end
        pwu_pa_vld_i   = 1'b0;
        pwu_pa_fault_i = 1'b0;
        chk("t2_drained", {28'd0, outst_o}, 32'd0);

        // T3: routing back to the issuer
        set_va(2, 32'h0000_1000);
        set_va(0, 32'h0000_2000);
        req_vld_i = 4'b0100;
        exp_iss(2);
        step();
        req_vld_i = 4'b0001;
        exp_iss(0);
        step();
        req_vld_i    = 4'b0000;
        pwu_pa_vld_i = 1'b1;
        pwu_pa_i     = 28'h0ABC000;
        exp_ret(2, 28'h0ABC000, 1'b0);
        step();
        pwu_pa_i = 28'h0DEF000;
        exp_ret(0, 28'h0DEF000, 1'b0);
        step();
        pwu_pa_vld_i = 1'b0;

        // Stalled grant: rr_ptr is 1, PWU not ready
        pwu_va_rdy_i = 1'b0;
        req_vld_i    = 4'hF;
        #1;
        chk("stall_va_vld", {31'd0, pwu_va_vld_o}, 32'd1);
        chk("stall_req_rdy", {28'd0, req_rdy_o}, 32'd0);
        chk("stall_va", pwu_va_o, 32'h2222_0004);
        step();

        // T4: fill to MAX_OUTST
        pwu_va_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) exp_iss((i + 1) % 4);
        repeat (8) step();
        chk("t4_full_outst", {28'd0, outst_o}, 32'd8);
        chk("t4_full_va_vld", {31'd0, pwu_va_vld_o}, 32'd0);
        chk("t4_full_req_rdy", {28'd0, req_rdy_o}, 32'd0);
        step();
        chk("t4_full_hold", {28'd0, outst_o}, 32'd8);
        pwu_pa_vld_i = 1'b1;
        pwu_pa_i     = 28'h0200001;
        exp_ret(1, 28'h0200001, 1'b0);
        #1;
        chk("t4_pop_blocks_issue", {31'd0, pwu_va_vld_o}, 32'd0);
        step();
        pwu_pa_vld_i = 1'b0;
        chk("t4_outst_7", {28'd0, outst_o}, 32'd7);
        #1;
        chk("t4_issue_resumes", {31'd0, pwu_va_vld_o}, 32'd1);
        exp_iss(1);
        step();
        req_vld_i = 4'h0;
        chk("t4_refull", {28'd0, outst_o}, 32'd8);

        // T5: backpressure on the head owner (requester 2)
        rsp_rdy_i    = 4'b1011;
        pwu_pa_vld_i = 1'b1;
        pwu_pa_i     = 28'h0300000;
        #1;
        chk("t5_bp_rsp_vld", {28'd0, rsp_vld_o}, 32'h4);
        chk("t5_bp_pa_rdy", {31'd0, pwu_pa_rdy_o}, 32'd0);
        step();
        chk("t5_bp_hold", {28'd0, outst_o}, 32'd8);
        rsp_rdy_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            pwu_pa_i = 28'h0300000 + 28'(i);
            exp_ret(ids2[i], pwu_pa_i, 1'b0);
            step();
        end
        pwu_pa_vld_i = 1'b0;
        chk("t5_drained", {28'd0, outst_o}, 32'd0);
        chk("t5_no_err", {31'd0, err_o}, 32'd0);

        // T5: response while empty -> sticky error
        pwu_pa_vld_i = 1'b1;
        #1;
        chk("orphan_pa_rdy", {31'd0, pwu_pa_rdy_o}, 32'd1);
        chk("orphan_rsp_vld", {28'd0, rsp_vld_o}, 32'd0);
        step();
        pwu_pa_vld_i = 1'b0;
        chk("err_set", {31'd0, err_o}, 32'd1);
        repeat (3) step();
        chk("err_sticky", {31'd0, err_o}, 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("err_cleared", {31'd0, err_o}, 32'd0);
        step();

`ifdef PWUARB_FAULT_CNT_EN
        // T6: three faulted responses to requester 1
        chk("fc_after_rst", fault_cnt_o[47:32], 32'd0);
        req_vld_i = 4'b0010;
        repeat (3) exp_iss(1);
        repeat (3) step();
        req_vld_i      = 4'b0000;
        pwu_pa_vld_i   = 1'b1;
        pwu_pa_fault_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pwu_pa_i = 28'h0F00000 + 28'(i);
            exp_ret(1, pwu_pa_i, 1'b1);
            step();
        end
        pwu_pa_vld_i = 1'b0;
        chk("fc_req1_3", {16'd0, fault_cnt_o[31:16]}, 32'd3);
        chk("fc_req0_0", {16'd0, fault_cnt_o[15:0]}, 32'd0);

        // Stream enough faults to pass 16'hFFFF
        req_vld_i = 4'b0010;
        exp_iss(1);
        step();
        pwu_pa_vld_i = 1'b1;
        for (int i = 0; i < 65532; i++) begin
            pwu_pa_i = 28'(i);
            exp_ret(1, pwu_pa_i, 1'b1);
            exp_iss(1);
            step();
        end
        req_vld_i = 4'b0000;
        pwu_pa_i  = 28'h0FFFFFF;
        exp_ret(1, pwu_pa_i, 1'b1);
        step();
        pwu_pa_vld_i   = 1'b0;
        pwu_pa_fault_i = 1'b0;
        chk("fc_saturated", {16'd0, fault_cnt_o[31:16]}, 32'h0000FFFF);
`endif

        step();
        chk("issue_queue_empty", exp_issue.size(), 32'd0);
        chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
